// File: rtl/neuron_mac_seq_if.sv
// Purpose: bundles the start/bias command, shared BRAM read port and result handshake of neuron_mac_seq.
// Latency: none, wiring only.
// Backpressure: result side is valid/ready; the slave holds the result while i_ready is low.
// Ports: slave modport = MAC side, master modport = controller/BRAM/downstream side.
interface neuron_mac_seq_if #(
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH      = 8,
  parameter int ACC_WIDTH       = 24
);
  logic                        i_start;
  logic [BRAM_ADDR_WIDTH-1:0]  i_base_addr;
  logic signed [ACC_WIDTH-1:0] i_bias;
  logic [BRAM_ADDR_WIDTH-1:0]  o_rd_addr;
  logic [DATA_WIDTH-1:0]       i_px_data;
  logic [DATA_WIDTH-1:0]       i_wt_data;
  logic                        o_busy;
  logic                        o_valid;
  logic                        i_ready;
  logic signed [ACC_WIDTH-1:0] o_result;
  logic                        o_sat;

  modport slave (
    input  i_start, i_base_addr, i_bias, i_px_data, i_wt_data, i_ready,
    output o_rd_addr, o_busy, o_valid, o_result, o_sat
  );

  modport master (
    output i_start, i_base_addr, i_bias, i_px_data, i_wt_data, i_ready,
    input  o_rd_addr, o_busy, o_valid, o_result, o_sat
  );
endinterface

// File: rtl/neuron_mac_seq.sv
// Purpose: sequential pixel x weight dot product over VEC_LEN BRAM words, saturating accumulate onto a bias.
// Latency: o_valid rises VEC_LEN+1 cycles after the start edge.
// Backpressure: result held in DONE until i_ready; starts are ignored while busy.
// Ports: i_clk, i_rst (sync, active high), bus (neuron_mac_seq_if.slave).
// Option: define NEURON_MAC_RELU_EN to clamp a negative final result to zero.
module neuron_mac_seq #(
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH      = 8,
  parameter int VEC_LEN         = 784,
  parameter int ACC_WIDTH       = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  neuron_mac_seq_if.slave  bus
);
  localparam int P_W   = 2*DATA_WIDTH + 1;
  localparam int CNT_W = BRAM_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0] rd_addr_q;
  logic [CNT_W-1:0]           count_q;
  logic [P_W-1:0]             p_q;
  logic                       pv_q;
  logic [ACC_WIDTH-1:0]       acc_q;
  logic                       sat_flag_q;
  logic [ACC_WIDTH-1:0]       result_q;
  logic                       sat_out_q;
  logic                       busy, valid;

  logic                       start_acc;
  logic signed [P_W-1:0]      px_ext, wt_ext, prod;
  logic [ACC_WIDTH:0]         sum_wide;
  logic [ACC_WIDTH-1:0]       acc_sat, result_fin;
  logic                       clamp;

  assign start_acc = (state_q == S_IDLE) && bus.i_start;

  // Pixel is unsigned, weight is signed; one spare bit keeps the product exact.
  assign px_ext = signed'({{(P_W-DATA_WIDTH){1'b0}}, bus.i_px_data});
  assign wt_ext = signed'({{(P_W-DATA_WIDTH){bus.i_wt_data[DATA_WIDTH-1]}}, bus.i_wt_data});
  assign prod   = px_ext * wt_ext;

  // One guard bit catches overflow; clamp towards the sign of the true sum.
  always_comb begin
    sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {{(ACC_WIDTH+1-P_W){p_q[P_W-1]}}, p_q};
    clamp    = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
    acc_sat  = sum_wide[ACC_WIDTH-1:0];
    if (clamp) begin
      acc_sat = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

`ifdef NEURON_MAC_RELU_EN
  assign result_fin = acc_sat[ACC_WIDTH-1] ? '0 : acc_sat;
`else
  assign result_fin = acc_sat;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.i_start) state_d = S_RUN;
      S_RUN:   if (count_q == CNT_W'(VEC_LEN-1)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (bus.i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy  = (state_q != S_IDLE);
    valid = (state_q == S_DONE);
  end

  // Datapath: product register feeds the accumulator one cycle later, so the
  // last product is folded in during DRAIN and the result is captured there.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_addr_q  <= '0;
      count_q    <= '0;
      p_q        <= '0;
      pv_q       <= 1'b0;
      acc_q      <= '0;
      sat_flag_q <= 1'b0;
      result_q   <= '0;
      sat_out_q  <= 1'b0;
    end else begin
      pv_q <= (state_q == S_RUN);
      if (state_q == S_RUN) p_q <= prod;

      if (start_acc) begin
        acc_q      <= bus.i_bias;
        sat_flag_q <= 1'b0;
        count_q    <= '0;
      end else begin
        if (pv_q) begin
          acc_q      <= acc_sat;
          sat_flag_q <= sat_flag_q | clamp;
        end
        if (state_q == S_RUN) count_q <= count_q + CNT_W'(1);
      end

      if (state_q == S_DRAIN) begin
        result_q  <= result_fin;
        sat_out_q <= sat_flag_q | clamp;
      end

      // Address parks at 0 whenever the sweep is not running.
      if (start_acc)             rd_addr_q <= bus.i_base_addr;
      else if (state_d == S_RUN) rd_addr_q <= rd_addr_q + BRAM_ADDR_WIDTH'(1);
      else                       rd_addr_q <= '0;
    end
  end

  assign bus.o_rd_addr = rd_addr_q;
  assign bus.o_busy    = busy;
  assign bus.o_valid   = valid;
  assign bus.o_result  = result_q;
  assign bus.o_sat     = sat_out_q;
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Purpose: directed self-checking bench for neuron_mac_seq (default, 17-bit/16-element, 8-element wrap builds).
// Latency: checks o_valid at VEC_LEN+1 cycles after start.
// Backpressure: exercises held result with i_ready low and ignored starts.
module tb_neuron_mac_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] px_mem [1024];
  logic [7:0] wt_mem [1024];

  neuron_mac_seq_if #(.BRAM_ADDR_WIDTH(10), .DATA_WIDTH(8), .ACC_WIDTH(24)) if_a ();
  neuron_mac_seq_if #(.BRAM_ADDR_WIDTH(10), .DATA_WIDTH(8), .ACC_WIDTH(17)) if_b ();
  neuron_mac_seq_if #(.BRAM_ADDR_WIDTH(10), .DATA_WIDTH(8), .ACC_WIDTH(24)) if_c ();

  neuron_mac_seq #(.BRAM_ADDR_WIDTH(10), .DATA_WIDTH(8), .VEC_LEN(784), .ACC_WIDTH(24))
    u_a (.i_clk(clk), .i_rst(rst), .bus(if_a.slave));
  neuron_mac_seq #(.BRAM_ADDR_WIDTH(10), .DATA_WIDTH(8), .VEC_LEN(16), .ACC_WIDTH(17))
    u_b (.i_clk(clk), .i_rst(rst), .bus(if_b.slave));
  neuron_mac_seq #(.BRAM_ADDR_WIDTH(10), .DATA_WIDTH(8), .VEC_LEN(8), .ACC_WIDTH(24))
    u_c (.i_clk(clk), .i_rst(rst), .bus(if_c.slave));

  assign if_a.i_px_data = px_mem[if_a.o_rd_addr];
  assign if_a.i_wt_data = wt_mem[if_a.o_rd_addr];
  assign if_b.i_px_data = px_mem[if_b.o_rd_addr];
  assign if_b.i_wt_data = wt_mem[if_b.o_rd_addr];
  assign if_c.i_px_data = px_mem[if_c.o_rd_addr];
  assign if_c.i_wt_data = wt_mem[if_c.o_rd_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic valid_of(input int w);
    case (w)
      0:       return if_a.o_valid;
      1:       return if_b.o_valid;
      default: return if_c.o_valid;
    endcase
  endfunction

  function automatic longint result_of(input int w);
    case (w)
      0:       return longint'(if_a.o_result);
      1:       return longint'(if_b.o_result);
      default: return longint'(if_c.o_result);
    endcase
  endfunction

  function automatic logic sat_of(input int w);
    case (w)
      0:       return if_a.o_sat;
      1:       return if_b.o_sat;
      default: return if_c.o_sat;
    endcase
  endfunction

  // Pulse start for one edge (the start edge E0); returns just after E0.
  task automatic start_only(input int w, input logic [9:0] base, input longint bias);
    case (w)
      0: begin if_a.i_base_addr = base; if_a.i_bias = 24'(bias); if_a.i_start = 1'b1; end
      1: begin if_b.i_base_addr = base; if_b.i_bias = 17'(bias); if_b.i_start = 1'b1; end
      default: begin if_c.i_base_addr = base; if_c.i_bias = 24'(bias); if_c.i_start = 1'b1; end
    endcase
    tick;
    if_a.i_start = 1'b0;
    if_b.i_start = 1'b0;
    if_c.i_start = 1'b0;
  endtask

  // Counts edges after E0 until o_valid, bounded.
  task automatic wait_valid(input int w, output int n);
    n = 0;
    while (!valid_of(w) && n < 3000) begin
      tick;
      n++;
    end
  endtask

  task automatic run(input int w, input logic [9:0] base, input longint bias, output int n);
    start_only(w, base, bias);
    wait_valid(w, n);
  endtask

  task automatic load_pattern(input logic [7:0] wt);
    for (int i = 0; i < 1024; i++) begin
      px_mem[i] = (i < 100) ? 8'((i % 5) + 1) : 8'd0;
      wt_mem[i] = wt;
    end
  endtask

  initial begin
    int n;
    int errs;
    longint r0;

    if_a.i_start = 1'b0; if_a.i_base_addr = '0; if_a.i_bias = '0; if_a.i_ready = 1'b1;
    if_b.i_start = 1'b0; if_b.i_base_addr = '0; if_b.i_bias = '0; if_b.i_ready = 1'b1;
    if_c.i_start = 1'b0; if_c.i_base_addr = '0; if_c.i_bias = '0; if_c.i_ready = 1'b1;
    load_pattern(8'd1);

    // Reset state
    tick; tick;
    check("rst_rd_addr", longint'(if_a.o_rd_addr), 0);
    check("rst_valid",   longint'(if_a.o_valid), 0);
    check("rst_busy",    longint'(if_a.o_busy), 0);
    check("rst_result",  result_of(0), 0);
    check("rst_sat",     longint'(if_a.o_sat), 0);
    rst = 1'b0;
    tick;

    // Pattern sum 20*(1+2+3+4+5) = 300 with unit weights
    start_only(0, 10'd0, 0);
    check("a_addr0", longint'(if_a.o_rd_addr), 0);
    check("a_busy",  longint'(if_a.o_busy), 1);
    wait_valid(0, n);
    n = n + 0;
    check("a_latency", longint'(n), 785);
    check("a_result",  result_of(0), 300);
    check("a_sat",     longint'(sat_of(0)), 0);
    tick;
    check("a_valid_drop", longint'(if_a.o_valid), 0);
    check("a_busy_drop",  longint'(if_a.o_busy), 0);

    // Weights -1, bias 10: 10 - 300
    load_pattern(8'hFF);
    run(0, 10'd0, 10, n);
    check("neg_latency", longint'(n), 785);
`ifdef NEURON_MAC_RELU_EN
    check("neg_result", result_of(0), 0);
`else
    check("neg_result", result_of(0), -290);
`endif
    check("neg_sat", longint'(sat_of(0)), 0);
    tick;

    // Saturation: 16*255*127 = 518160 exceeds 17-bit signed max 65535
    for (int i = 0; i < 1024; i++) begin
      px_mem[i] = (i < 16) ? 8'd255 : 8'd0;
      wt_mem[i] = (i < 16) ? 8'd127 : 8'd0;
    end
    run(1, 10'd0, 0, n);
    check("sat_latency", longint'(n), 17);
    check("sat_result",  result_of(1), 65535);
    check("sat_flag",    longint'(sat_of(1)), 1);
    tick;
    for (int i = 0; i < 1024; i++) wt_mem[i] = 8'd0;
    run(1, 10'd0, 5, n);
    check("clr_result", result_of(1), 5);
    check("clr_sat",    longint'(sat_of(1)), 0);
    tick;

    // Backpressure: hold ready low for 6 cycles, pulse start meanwhile
    load_pattern(8'd1);
    if_a.i_ready = 1'b0;
    run(0, 10'd0, 0, n);
    r0 = result_of(0);
    check("hold_result", r0, 300);
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      if_a.i_start = (i == 2);
      tick;
      if (if_a.o_valid !== 1'b1 || result_of(0) != r0) errs++;
    end
    if_a.i_start = 1'b0;
    check("hold_stable", longint'(errs), 0);
    if_a.i_ready = 1'b1;
    tick;
    check("hold_valid_drop", longint'(if_a.o_valid), 0);
    check("hold_busy_drop",  longint'(if_a.o_busy), 0);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (if_a.o_busy !== 1'b0 || if_a.o_valid !== 1'b0) errs++;
    end
    check("hold_no_restart", longint'(errs), 0);

    // Reset at cycle 50 of RUN abandons the operation
    start_only(0, 10'd0, 0);
    for (int i = 0; i < 50; i++) tick;
    check("mid_busy", longint'(if_a.o_busy), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_valid",   longint'(if_a.o_valid), 0);
    check("mid_busy0",   longint'(if_a.o_busy), 0);
    check("mid_rd_addr", longint'(if_a.o_rd_addr), 0);
    run(0, 10'd0, 0, n);
    check("re_latency", longint'(n), 785);
    check("re_result",  result_of(0), 300);
    tick;

    // Address wrap: base 1020, 8 elements
    for (int i = 0; i < 1024; i++) begin
      px_mem[i] = 8'd0;
      wt_mem[i] = 8'd0;
    end
    px_mem[1020] = 8'd10; wt_mem[1020] = 8'd1;
    px_mem[1021] = 8'd20; wt_mem[1021] = 8'hFE;
    px_mem[1022] = 8'd30; wt_mem[1022] = 8'd3;
    px_mem[1023] = 8'd40; wt_mem[1023] = 8'hFC;
    px_mem[0]    = 8'd1;  wt_mem[0]    = 8'd5;
    px_mem[1]    = 8'd2;  wt_mem[1]    = 8'd6;
    px_mem[2]    = 8'd3;  wt_mem[2]    = 8'd7;
    px_mem[3]    = 8'd4;  wt_mem[3]    = 8'd8;
    start_only(2, 10'd1020, 0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("wrap_addr%0d", k), longint'(if_c.o_rd_addr), longint'((1020 + k) % 1024));
      tick;
    end
    wait_valid(2, n);
    check("wrap_latency", longint'(n + 8), 9);
`ifdef NEURON_MAC_RELU_EN
    check("wrap_result", result_of(2), 0);
`else
    check("wrap_result", result_of(2), -30);
`endif
    check("wrap_sat", longint'(sat_of(2)), 0);
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
